// File: rtl/encode_4_2_pend.sv
// Sequential 4-to-2 encoder: collects request pulses into a pending register and
// offers one index per valid/ready handshake. Build option: ROUND_ROBIN_EN.
module encode_4_2_pend #(
  parameter logic [1:0] OUT_RESET        = 2'b00,
  parameter bit         DRAIN_ON_DISABLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_n,
  input  logic [3:0] indata,
  output logic [1:0] outdata,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] pending,
  output logic       busy
);

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state;
  logic [IW-1:0] sel_c;
  logic          sel_en_c;
  logic          load_c;
  logic [N-1:0]  load_mask_c;
  logic [N-1:0]  req_c;

`ifdef ROUND_ROBIN_EN
  logic [IW-1:0] rr_ptr;

  // Round-robin search from rr_ptr+1 upward with wrap; the nearest set bit wins.
  always_comb begin
    sel_c = '0;
    for (int k = N; k >= 1; k--) begin
      if (pending[IW'(rr_ptr + IW'(k))]) begin
        sel_c = IW'(rr_ptr + IW'(k));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= IW'(N - 1);
    end else if (load_c) begin
      rr_ptr <= sel_c;
    end
  end
`else
  // Fixed priority: the highest set pending bit wins.
  always_comb begin
    sel_c = '0;
    for (int i = 0; i < N; i++) begin
      if (pending[i]) begin
        sel_c = IW'(i);
      end
    end
  end
`endif

  // A load happens when something is pending, selection is allowed and the
  // output slot is free or being freed on this edge.
  always_comb begin
    sel_en_c    = DRAIN_ON_DISABLE || !enable_n;
    load_c      = sel_en_c && (|pending) && ((state == IDLE) || out_ready);
    load_mask_c = load_c ? (N'(1) << sel_c) : '0;
    req_c       = enable_n ? '0 : indata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      outdata   <= OUT_RESET;
      out_valid <= 1'b0;
      pending   <= '0;
    end else begin
      // New requests are applied after the clear, so a same-cycle re-request survives.
      pending <= (pending & ~load_mask_c) | req_c;
      case (state)
        IDLE: begin
          if (load_c) begin
            outdata   <= sel_c;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (load_c) begin
              outdata <= sel_c;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy = out_valid | (|pending);

endmodule

// File: tb/tb_encode_4_2_pend.sv
// Self-checking bench for encode_4_2_pend: directed scenarios plus randomized
// traffic against a request-set reference model.
`timescale 1ns/1ps
module tb_encode_4_2_pend;

  localparam logic [1:0] OUT_RST = 2'b00;
  localparam bit         DRAIN   = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable_n = 1'b1;
  logic [3:0] indata = 4'b0;
  logic [1:0] outdata;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] pending;
  logic       busy;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit [3:0] m_pend;
  int       m_out;
  bit       m_valid;
  int       m_rr;

  encode_4_2_pend #(.OUT_RESET(OUT_RST), .DRAIN_ON_DISABLE(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n), .enable_n(enable_n), .indata(indata),
    .outdata(outdata), .out_valid(out_valid), .out_ready(out_ready),
    .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int pick(input bit [3:0] p, input int rr);
    int r;
    r = 0;
`ifdef ROUND_ROBIN_EN
    for (int k = 4; k >= 1; k--) if (p[(rr + k) % 4]) r = (rr + k) % 4;
`else
    for (int i = 3; i >= 0; i--) if (p[i]) return i;
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_pend = 4'b0; m_out = int'(OUT_RST); m_valid = 1'b0; m_rr = 3;
  endtask

  task automatic model_edge(input bit en_n, input bit [3:0] ind, input bit rdy);
    bit [3:0] clr;
    int idx;
    clr = 4'b0;
    if (m_pend != 0 && (DRAIN || !en_n) && (!m_valid || rdy)) begin
      idx = pick(m_pend, m_rr);
      clr[idx] = 1'b1;
      m_out = idx; m_valid = 1'b1; m_rr = idx;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    m_pend = (m_pend & ~clr) | (en_n ? 4'b0 : ind);
  endtask

  // Drive one cycle of inputs, clock it, and step the model; returns at edge+1.
  task automatic cycle(input bit en_n, input bit [3:0] ind, input bit rdy);
    enable_n = en_n; indata = ind; out_ready = rdy;
    @(posedge clk);
    model_edge(en_n, ind, rdy);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    enable_n = 1'b1; indata = 4'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2 rst_n = 1'b1;
    cycle(1'b1, 4'b0, 1'b0);
  endtask

  task automatic test_reset();
    #3;
    checks++; if (outdata !== OUT_RST || out_valid !== 1'b0 || pending !== 4'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_initial got out=%0d v=%b p=%b busy=%b", outdata, out_valid, pending, busy);
    end
    model_reset();
    #2 rst_n = 1'b1;
    cycle(1'b1, 4'b0, 1'b0);
    cycle(1'b0, 4'b1010, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);
    checks++; if (outdata !== 2'd3 || out_valid !== 1'b1 || pending !== 4'b0010) begin
      failures++; $display("FAIL reset_setup got out=%0d v=%b p=%b exp out=3 v=1 p=0010", outdata, out_valid, pending);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (outdata !== OUT_RST || out_valid !== 1'b0 || pending !== 4'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_async got out=%0d v=%b p=%b busy=%b exp all zero", outdata, out_valid, pending, busy);
    end
    model_reset();
    #2 rst_n = 1'b1;
    cycle(1'b1, 4'b0, 1'b0);
  endtask

  task automatic test_single();
    apply_reset();
    cycle(1'b0, 4'b0100, 1'b1);
    checks++; if (pending !== 4'b0100 || out_valid !== 1'b0) begin
      failures++; $display("FAIL single_capture got p=%b v=%b exp p=0100 v=0", pending, out_valid);
    end
    cycle(1'b0, 4'b0000, 1'b1);
    checks++; if (outdata !== 2'd2 || out_valid !== 1'b1 || pending !== 4'b0) begin
      failures++; $display("FAIL single_offer got out=%0d v=%b p=%b exp out=2 v=1 p=0000", outdata, out_valid, pending);
    end
    cycle(1'b0, 4'b0000, 1'b1);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || outdata !== 2'd2) begin
      failures++; $display("FAIL single_done got v=%b busy=%b out=%0d exp v=0 busy=0 out=2", out_valid, busy, outdata);
    end
  endtask

  task automatic test_multi();
    int exp_seq[3];
`ifdef ROUND_ROBIN_EN
    exp_seq = '{0, 1, 3};
`else
    exp_seq = '{3, 1, 0};
`endif
    apply_reset();
    cycle(1'b0, 4'b1011, 1'b1);
    checks++; if (pending !== 4'b1011) begin
      failures++; $display("FAIL multi_capture got p=%b exp p=1011", pending);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'b0000, 1'b1);
      checks++; if (outdata !== 2'(exp_seq[i]) || out_valid !== 1'b1) begin
        failures++; $display("FAIL multi_seq%0d got out=%0d v=%b exp out=%0d v=1", i, outdata, out_valid, exp_seq[i]);
      end
    end
    cycle(1'b0, 4'b0000, 1'b1);
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL multi_idle got busy=%b v=%b exp 0 0", busy, out_valid);
    end
  endtask

  task automatic test_back_pressure();
    apply_reset();
    cycle(1'b0, 4'b0100, 1'b0);
    cycle(1'b0, 4'b0001, 1'b0);
    checks++; if (outdata !== 2'd2 || out_valid !== 1'b1 || pending !== 4'b0001) begin
      failures++; $display("FAIL bp_offer got out=%0d v=%b p=%b exp out=2 v=1 p=0001", outdata, out_valid, pending);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, (i == 0) ? 4'b1000 : 4'b0000, 1'b0);
      checks++; if (outdata !== 2'd2 || out_valid !== 1'b1 || pending !== 4'b1001) begin
        failures++; $display("FAIL bp_hold%0d got out=%0d v=%b p=%b exp out=2 v=1 p=1001", i, outdata, out_valid, pending);
      end
    end
    cycle(1'b0, 4'b0000, 1'b1);
    checks++; if (out_valid !== 1'b1 || pending !== ((outdata == 2'd3) ? 4'b0001 : 4'b1000)) begin
      failures++; $display("FAIL bp_release got out=%0d v=%b p=%b", outdata, out_valid, pending);
    end
`ifndef ROUND_ROBIN_EN
    checks++; if (outdata !== 2'd3) begin
      failures++; $display("FAIL bp_release_idx got out=%0d exp 3", outdata);
    end
`endif
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    checks++; if (busy !== 1'b0) begin
      failures++; $display("FAIL bp_drain got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_disable_coalesce();
    int served0;
    served0 = 0;
    apply_reset();
    cycle(1'b0, 4'b0101, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);
    checks++; if (outdata !== 2'd2 || pending !== 4'b0001) begin
      failures++; $display("FAIL dis_setup got out=%0d p=%b exp out=2 p=0001", outdata, pending);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 4'b1111, 1'b0);
      checks++; if (pending !== 4'b0001) begin
        failures++; $display("FAIL dis_ignore%0d got p=%b exp p=0001", i, pending);
      end
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 4'b0001, 1'b0);
      checks++; if (pending !== 4'b0001) begin
        failures++; $display("FAIL dis_coalesce%0d got p=%b exp p=0001", i, pending);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 4'b0000, 1'b1);
      if (out_valid === 1'b1 && outdata === 2'd0) served0++;
    end
    checks++; if (served0 !== 1 || busy !== 1'b0) begin
      failures++; $display("FAIL dis_served got served0=%0d busy=%b exp 1 0", served0, busy);
    end
  endtask

  task automatic test_rr_alternate();
    int exp_idx;
    apply_reset();
    cycle(1'b0, 4'b1001, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 4'b1001, 1'b1);
`ifdef ROUND_ROBIN_EN
      exp_idx = (i % 2 == 0) ? 0 : 3;
`else
      exp_idx = 3;
`endif
      checks++; if (outdata !== 2'(exp_idx) || out_valid !== 1'b1 || pending !== 4'b1001) begin
        failures++; $display("FAIL rr_grant%0d got out=%0d v=%b p=%b exp out=%0d v=1 p=1001", i, outdata, out_valid, pending, exp_idx);
      end
    end
  endtask

  task automatic test_random();
    bit       en_n, rdy;
    bit [3:0] ind;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      en_n = ($urandom_range(0, 4) == 0);
      ind  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      rdy  = ($urandom_range(0, 3) != 0);
      cycle(en_n, ind, rdy);
      checks++; if (pending !== m_pend) begin
        failures++; $display("FAIL rand_pending cyc=%0d got=%b exp=%b", c, pending, m_pend);
      end
      checks++; if (out_valid !== m_valid) begin
        failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, out_valid, m_valid);
      end
      checks++; if (outdata !== 2'(m_out)) begin
        failures++; $display("FAIL rand_outdata cyc=%0d got=%0d exp=%0d", c, outdata, m_out);
      end
      checks++; if (busy !== (m_valid || m_pend != 0)) begin
        failures++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", c, busy, (m_valid || m_pend != 0));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_multi();
    test_back_pressure();
    test_disable_coalesce();
    test_rr_alternate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
